// File: rtl/machine_ctrl.sv
// ----------------------------------------------------------------------------
// machine_ctrl
//
// Per-instruction sequencer for the 8-cycle CPU. It follows the phase
// protocol produced by the clock generator (fetch / con_alu), locks onto the
// first fetch=1 it sees, and then steps through S0..S7 once per instruction.
// The datapath strobes are a combinational decode of the current state, the
// IR opcode and the accumulator-zero flag.
//
// While locked, every state leaving edge compares fetch/con_alu with the
// values the generator should be presenting at that phase. Any disagreement
// latches phase_err and drops the sequencer back to IDLE, so it relocks on the
// next fetch=1.
//
// Parameters
//   CHECK_EN   1: phase checking active; 0: checking off, o_phase_err stays 0
//   ALU_PHASE  index k of the state Sk whose leaving edge must see con_alu=1
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_fetch        1 during the 4 fetch cycles, 0 during the 4 execute cycles
//   i_con_alu      one-cycle ALU strobe, once per 8-cycle period
//   i_opcode[2:0]  000 HLT 001 SKZ 010 ADD 011 AND 100 XOR 101 LDA 110 STO 111 JMP
//   i_zero         accumulator is zero (SKZ condition)
//   o_inc_pc       increment PC
//   o_load_acc     load accumulator from ALU
//   o_load_pc      load PC from IR address field
//   o_rd           memory read
//   o_wr           memory write
//   o_load_ir      load an IR byte from the data bus
//   o_datactl_ena  drive ACC onto the data bus
//   o_halt         CPU halted, sticky until reset
//   o_phase_err    phase misalignment seen, sticky until reset
//   o_state[3:0]   current sequencer state (debug visibility)
// ----------------------------------------------------------------------------
module machine_ctrl #(
    parameter bit          CHECK_EN  = 1'b1,
    parameter int unsigned ALU_PHASE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_fetch,
    input  logic       i_con_alu,
    input  logic [2:0] i_opcode,
    input  logic       i_zero,
    output logic       o_inc_pc,
    output logic       o_load_acc,
    output logic       o_load_pc,
    output logic       o_rd,
    output logic       o_wr,
    output logic       o_load_ir,
    output logic       o_datactl_ena,
    output logic       o_halt,
    output logic       o_phase_err,
    output logic [3:0] o_state
);

    // S0..S7 occupy codes 1..8 so the phase index is simply code-1 (mod 8).
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_S0   = 4'd1,
        ST_S1   = 4'd2,
        ST_S2   = 4'd3,
        ST_S3   = 4'd4,
        ST_S4   = 4'd5,
        ST_S5   = 4'd6,
        ST_S6   = 4'd7,
        ST_S7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    localparam logic [2:0] ALU_IDX = 3'(ALU_PHASE);

    state_t     r_state;
    logic       r_phase_err;

    logic       w_in_seq;
    logic [2:0] w_phase;
    logic       w_exp_fetch;
    logic       w_exp_alu;
    logic       w_mismatch;
    state_t     w_seq_next;

    logic       w_op_hlt;
    logic       w_op_skz;
    logic       w_op_alu;
    logic       w_op_sto;
    logic       w_op_jmp;

    logic       w_inc_pc;
    logic       w_load_acc;
    logic       w_load_pc;
    logic       w_rd;
    logic       w_wr;
    logic       w_load_ir;
    logic       w_datactl_ena;

    // ------------------------------------------------------------------
    // Phase tracking
    // ------------------------------------------------------------------
    assign w_in_seq = (r_state >= ST_S0) && (r_state <= ST_S7);

    // S7 is code 8, whose low bits are 0; subtracting 1 wraps it to 7.
    assign w_phase = r_state[2:0] - 3'd1;

    // fetch is high for the generator slots lining up with S7, S0, S1, S2.
    assign w_exp_fetch = (w_phase == 3'd0) || (w_phase == 3'd1) ||
                         (w_phase == 3'd2) || (w_phase == 3'd7);
    assign w_exp_alu   = (w_phase == ALU_IDX);

    assign w_mismatch = CHECK_EN && w_in_seq &&
                        ((i_fetch != w_exp_fetch) || (i_con_alu != w_exp_alu));

    assign w_seq_next = (r_state == ST_S7) ? ST_S0 : state_t'(r_state + 4'd1);

    // ------------------------------------------------------------------
    // Opcode classes
    // ------------------------------------------------------------------
    assign w_op_hlt = (i_opcode == 3'b000);
    assign w_op_skz = (i_opcode == 3'b001);
    assign w_op_alu = (i_opcode == 3'b010) || (i_opcode == 3'b011) ||
                      (i_opcode == 3'b100) || (i_opcode == 3'b101);
    assign w_op_sto = (i_opcode == 3'b110);
    assign w_op_jmp = (i_opcode == 3'b111);

    // ------------------------------------------------------------------
    // Sequencer state and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_phase_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_fetch) begin
                        r_state <= ST_S0;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    // A misaligned edge wins over everything, including the
                    // HLT exit from S3: we cannot trust the opcode then.
                    if (w_mismatch) begin
                        r_phase_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if ((r_state == ST_S3) && w_op_hlt) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= w_seq_next;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe decode. rd and wr/datactl_ena are never set in the same state
    // for the same opcode class, which keeps the bus free of contention.
    // ------------------------------------------------------------------
    always_comb begin
        w_inc_pc      = 1'b0;
        w_load_acc    = 1'b0;
        w_load_pc     = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_load_ir     = 1'b0;
        w_datactl_ena = 1'b0;
        case (r_state)
            ST_S0: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
            end
            ST_S1: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
            end
            ST_S3: begin
                w_inc_pc = !w_op_hlt;
            end
            ST_S4: begin
                w_load_pc     = w_op_jmp;
                w_rd          = w_op_alu;
                w_datactl_ena = w_op_sto;
            end
            ST_S5: begin
                w_rd          = w_op_alu;
                w_load_acc    = w_op_alu;
                w_inc_pc      = (w_op_skz && i_zero) || w_op_jmp;
                w_load_pc     = w_op_jmp;
                w_wr          = w_op_sto;
                w_datactl_ena = w_op_sto;
            end
            ST_S6: begin
                w_datactl_ena = w_op_sto;
                w_rd          = w_op_alu;
            end
            ST_S7: begin
                w_inc_pc = w_op_skz && i_zero;
            end
            default: begin
            end
        endcase
    end

    assign o_inc_pc      = w_inc_pc;
    assign o_load_acc    = w_load_acc;
    assign o_load_pc     = w_load_pc;
    assign o_rd          = w_rd;
    assign o_wr          = w_wr;
    assign o_load_ir     = w_load_ir;
    assign o_datactl_ena = w_datactl_ena;
    assign o_halt        = (r_state == ST_HALT);
    assign o_phase_err   = r_phase_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_machine_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for machine_ctrl. Two instances share the same inputs: one with phase
// checking on, one with it off. A generator slot counter g (0..7) plays the
// clock generator; single-cycle glitches on fetch/con_alu create
// misalignment. A behavioural model tracks lock position, halt and the error
// flag with plain integers and derives the expected strobes from the
// per-state table.
// Output vector bit order: {inc_pc, load_acc, load_pc, rd, wr, load_ir,
//                           datactl_ena, halt, phase_err}
// ----------------------------------------------------------------------------
module tb_machine_ctrl;

  localparam int ALU_P = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fetch;
  logic       con_alu;
  logic [2:0] opcode;
  logic       zero;
  logic [8:0] out0;
  logic [8:0] out1;
  logic [3:0] st0;
  logic [3:0] st1;

  machine_ctrl #(.CHECK_EN(1'b1), .ALU_PHASE(ALU_P)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_fetch(fetch), .i_con_alu(con_alu),
    .i_opcode(opcode), .i_zero(zero),
    .o_inc_pc(out0[8]), .o_load_acc(out0[7]), .o_load_pc(out0[6]),
    .o_rd(out0[5]), .o_wr(out0[4]), .o_load_ir(out0[3]),
    .o_datactl_ena(out0[2]), .o_halt(out0[1]), .o_phase_err(out0[0]),
    .o_state(st0)
  );

  machine_ctrl #(.CHECK_EN(1'b0), .ALU_PHASE(ALU_P)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_fetch(fetch), .i_con_alu(con_alu),
    .i_opcode(opcode), .i_zero(zero),
    .o_inc_pc(out1[8]), .o_load_acc(out1[7]), .o_load_pc(out1[6]),
    .o_rd(out1[5]), .o_wr(out1[4]), .o_load_ir(out1[3]),
    .o_datactl_ena(out1[2]), .o_halt(out1[1]), .o_phase_err(out1[0]),
    .o_state(st1)
  );

  // scoreboard
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h st0=%0d st1=%0d t=%0t", tag, got, exp, st0, st1, $time);
    end
  endtask

  // reference model: k = -1 idle, 0..7 position in instruction, 8 halted
  int m_k[2];
  bit m_perr[2];
  bit m_ce[2];

  function automatic bit exp_fetch(input int k);
    return (k == 0) || (k == 1) || (k == 2) || (k == 7);
  endfunction

  function automatic logic [8:0] model_out(input int k, input logic [2:0] op, input bit z,
                                           input bit perr);
    bit inc = 0, acc = 0, lpc = 0, rd = 0, wr = 0, lir = 0, dct = 0, hlt = 0;
    bit alu_ld = (op >= 3'd2) && (op <= 3'd5);
    case (k)
      0: begin rd = 1; lir = 1; end
      1: begin rd = 1; lir = 1; inc = 1; end
      3: inc = (op != 3'd0);
      4: begin lpc = (op == 3'd7); rd = alu_ld; dct = (op == 3'd6); end
      5: begin
        if (alu_ld) begin rd = 1; acc = 1; end
        if (op == 3'd1 && z) inc = 1;
        if (op == 3'd7) begin inc = 1; lpc = 1; end
        if (op == 3'd6) begin wr = 1; dct = 1; end
      end
      6: begin dct = (op == 3'd6); rd = alu_ld; end
      7: inc = (op == 3'd1) && z;
      8: hlt = 1;
      default: ;
    endcase
    return {inc, acc, lpc, rd, wr, lir, dct, hlt, perr};
  endfunction

  function automatic void model_next(input int k, input bit perr, input bit f, input bit c,
                                     input logic [2:0] op, input bit ce,
                                     output int nk, output bit nperr);
    nk = k;
    nperr = perr;
    if (k == -1) begin
      if (f) nk = 0;
    end else if (k != 8) begin
      if (ce && ((f != exp_fetch(k)) || (c != (k == ALU_P)))) begin
        nperr = 1;
        nk = -1;
      end else if (k == 3 && op == 3'd0) begin
        nk = 8;
      end else begin
        nk = (k + 1) % 8;
      end
    end
  endfunction

  // driver
  int         g;
  logic [2:0] cur_op;
  bit         cur_z;
  logic [2:0] op_q[$];
  bit         z_q[$];

  task automatic step(input bit f, input bit c, input logic [2:0] op, input bit z, input bit r);
    int nk;
    bit np;
    @(negedge clk);
    fetch = f; con_alu = c; opcode = op; zero = z; rst = r;
    if (r) begin
      for (int i = 0; i < 2; i++) begin m_k[i] = -1; m_perr[i] = 0; end
    end
    for (int i = 0; i < 2; i++) exp_q.push_back(model_out(m_k[i], op, z, m_perr[i]));
    #1;
    chk("dut0_strobes", 16'(out0), 16'(exp_q.pop_front()));
    chk("dut1_strobes", 16'(out1), 16'(exp_q.pop_front()));
    chk("rd_wr_excl", 16'(out0[5] & out0[4]), 16'd0);
    chk("rd_dct_excl", 16'(out0[5] & out0[2]), 16'd0);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        model_next(m_k[i], m_perr[i], f, c, op, m_ce[i], nk, np);
        m_k[i] = nk;
        m_perr[i] = np;
      end
    end
  endtask

  task automatic gen_cycle(input bit gf, input bit gc, input bit r);
    bit f, c;
    if (g == 0) begin
      if (op_q.size() > 0) begin
        cur_op = op_q.pop_front();
        cur_z = z_q.pop_front();
      end else begin
        cur_op = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        cur_z = 1'($urandom_range(0, 1));
      end
    end
    f = exp_fetch(g) ^ gf;
    c = (g == ALU_P) ^ gc;
    step(f, c, cur_op, cur_z, r);
    g = (g + 1) % 8;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, cur_op, cur_z, 1'b1);
    step(1'b0, 1'b0, cur_op, cur_z, 1'b1);
    g = 3;
  endtask

  task automatic handle_halt();
    if (m_k[0] == 8) begin
      repeat (24) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      #1;
      chk("halt_held", 16'(out0[1]), 16'd1);
      do_reset();
    end
  endtask

  initial begin
    m_ce[0] = 1; m_ce[1] = 0;
    m_k[0] = -1; m_k[1] = -1; m_perr[0] = 0; m_perr[1] = 0;
    fetch = 0; con_alu = 0; opcode = 3'd2; zero = 0; rst = 1;
    cur_op = 3'd2; cur_z = 0;

    // directed program: ADD STO SKZ(z=1) SKZ(z=0) JMP LDA AND XOR, then
    // ADD (misaligned), ADD (clean), ADD (reset mid-S5), HLT
    op_q = '{3'd2, 3'd6, 3'd1, 3'd1, 3'd7, 3'd5, 3'd3, 3'd4, 3'd2, 3'd2, 3'd2, 3'd0};
    z_q  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    do_reset();
    repeat (5) gen_cycle(1'b0, 1'b0, 1'b0);        // g 3..7, lock on g=7
    repeat (64) gen_cycle(1'b0, 1'b0, 1'b0);       // eight clean instructions

    // extra fetch sampled 1 on the S3 edge
    for (int i = 0; i < 8; i++) gen_cycle(g == 3, 1'b0, 1'b0);
    #1;
    chk("perr_set", 16'(out0[0]), 16'd1);
    chk("nocheck_no_err", 16'(out1[0]), 16'd0);
    repeat (8) gen_cycle(1'b0, 1'b0, 1'b0);
    #1;
    chk("perr_sticky", 16'(out0[0]), 16'd1);

    // reset asserted during S5 of an ADD
    repeat (5) gen_cycle(1'b0, 1'b0, 1'b0);
    gen_cycle(1'b0, 1'b0, 1'b1);
    do_reset();
    #1;
    chk("perr_cleared", 16'(out0[0]), 16'd0);

    // HLT
    repeat (13) gen_cycle(1'b0, 1'b0, 1'b0);
    #1;
    chk("halt_entered", 16'(out0[1]), 16'd1);
    handle_halt();

    // randomized run
    repeat (3000) begin
      gen_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 499) == 0);
      handle_halt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
